// File: rtl/mux_16to1.sv
// 16-way lane selector with optional output register.
// Lane k occupies In[k*DATA_W +: DATA_W]; lane 0 is the LSB lane.
module mux_16to1 #(
    parameter int DATA_W  = 1,
    parameter bit OUT_REG = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [16*DATA_W-1:0] In,
    input  logic [3:0]           Sel,
    output logic [DATA_W-1:0]    Out,
    output logic                 out_valid,
    output logic [3:0]           out_sel
);

    logic [DATA_W-1:0] lanes [16];
    logic [DATA_W-1:0] sel_data;

    for (genvar k = 0; k < 16; k++) begin : g_lane
        assign lanes[k] = In[k*DATA_W +: DATA_W];
    end

    assign sel_data = lanes[Sel];

    if (OUT_REG) begin : g_reg
        // Out/out_sel hold while idle; only out_valid drops.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                Out       <= '0;
                out_sel   <= '0;
                out_valid <= 1'b0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    Out     <= sel_data;
                    out_sel <= Sel;
                end
            end
        end
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clk, rst_n};
        assign Out       = sel_data;
        assign out_sel   = Sel;
        assign out_valid = in_valid;
    end

endmodule

// File: tb/tb_mux_16to1.sv
// Bench for mux_16to1: registered 1-bit instance plus a
// combinational 8-bit instance, checked against a shift-based model.
module tb_mux_16to1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [15:0]  in1;
    logic [3:0]   sel1;
    logic         out1;
    logic         ov1;
    logic [3:0]   os1;

    logic         v2;
    logic [127:0] in2;
    logic [3:0]   sel2;
    logic [7:0]   out2;
    logic         ov2;
    logic [3:0]   os2;

    int tests = 0;
    int fails = 0;

    logic       m_out;
    logic [3:0] m_sel;
    logic       m_valid;

    always #5 clk = ~clk;

    mux_16to1 #(.DATA_W(1), .OUT_REG(1'b1)) u_reg (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .In(in1), .Sel(sel1), .Out(out1),
        .out_valid(ov1), .out_sel(os1)
    );

    mux_16to1 #(.DATA_W(8), .OUT_REG(1'b0)) u_comb (
        .clk(clk), .rst_n(rst_n), .in_valid(v2),
        .In(in2), .Sel(sel2), .Out(out2),
        .out_valid(ov2), .out_sel(os2)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic pick1(input logic [15:0] d, input int s);
        logic [15:0] t;
        t = d >> s;
        return t[0];
    endfunction

    function automatic logic [7:0] pick8(input logic [127:0] d, input int s);
        logic [127:0] t;
        t = d >> (s * 8);
        return t[7:0];
    endfunction

    task automatic chk_model(input string tag);
        chk({tag, ".out"}, {7'd0, out1}, {7'd0, m_out});
        chk({tag, ".sel"}, {4'd0, os1}, {4'd0, m_sel});
        chk({tag, ".valid"}, {7'd0, ov1}, {7'd0, m_valid});
    endtask

    // Drive one cycle, advance the model at the edge, check just after.
    task automatic cycle(input logic v, input logic [15:0] d,
                         input logic [3:0] s, input string tag);
        in_valid = v;
        in1      = d;
        sel1     = s;
        @(posedge clk);
        if (rst_n) begin
            m_valid = v;
            if (v) begin
                m_out = pick1(d, int'(s));
                m_sel = s;
            end
        end
        #1;
        chk_model(tag);
    endtask

    initial begin
        // 1: asynchronous reset, no edge yet
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in1      = 16'hFFFF;
        sel1     = 4'd5;
        v2       = 1'b0;
        in2      = '0;
        sel2     = '0;
        m_out    = 1'b0;
        m_sel    = 4'd0;
        m_valid  = 1'b0;
        #2;
        chk("rst.out", {7'd0, out1}, 8'h00);
        chk("rst.valid", {7'd0, ov1}, 8'h00);
        chk("rst.sel", {4'd0, os1}, 8'h00);
        @(posedge clk);
        #1;
        chk("rst_edge.out", {7'd0, out1}, 8'h00);
        rst_n = 1'b1;

        // 2: alternating pattern sweep
        for (int s = 0; s < 16; s++) begin
            cycle(1'b1, 16'b1010101010101010, 4'(s), "sweep");
            chk("sweep.lsb", {7'd0, out1}, {7'd0, 1'(s % 2)});
        end

        // 3: F0F0 sweep with explicit expectations
        for (int s = 0; s < 16; s++) begin
            cycle(1'b1, 16'hF0F0, 4'(s), "f0f0");
            chk("f0f0.exp", {7'd0, out1},
                {7'd0, 1'((s >= 4 && s < 8) || s >= 12)});
        end

        // 4: hold while idle
        cycle(1'b1, 16'h0008, 4'd3, "hold.cap");
        chk("hold.cap1", {7'd0, out1}, 8'h01);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 16'h0000, 4'd0, "hold");
            chk("hold.out1", {7'd0, out1}, 8'h01);
            chk("hold.sel3", {4'd0, os1}, 8'h03);
            chk("hold.v0", {7'd0, ov1}, 8'h00);
        end

        // 5: reset mid-stream, between edges
        cycle(1'b1, 16'h0100, 4'd8, "pre_rst");
        chk("pre_rst.one", {7'd0, out1}, 8'h01);
        #2;
        rst_n   = 1'b0;
        m_out   = 1'b0;
        m_sel   = 4'd0;
        m_valid = 1'b0;
        #1;
        chk_model("midrst");
        @(posedge clk);
        #1;
        chk_model("midrst_edge");
        rst_n = 1'b1;
        cycle(1'b1, 16'h0002, 4'd1, "post_rst");
        chk("post_rst.one", {7'd0, out1}, 8'h01);

        // Random traffic on the registered instance
        for (int i = 0; i < 60; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 16'($urandom),
                  4'($urandom_range(0, 15)), "rand");
        end

        // 6: combinational 8-bit instance
        for (int k = 0; k < 16; k++) in2[k*8 +: 8] = 8'(8'h10 + k);
        sel2 = 4'd9;
        v2   = 1'b1;
        #1;
        chk("comb.out", out2, 8'h19);
        chk("comb.valid", {7'd0, ov2}, 8'h01);
        chk("comb.sel", {4'd0, os2}, 8'h09);
        v2 = 1'b0;
        #1;
        chk("comb.valid0", {7'd0, ov2}, 8'h00);
        for (int i = 0; i < 30; i++) begin
            in2  = {$urandom, $urandom, $urandom, $urandom};
            sel2 = 4'($urandom_range(0, 15));
            v2   = 1'($urandom_range(0, 1));
            #1;
            chk("comb.rand", out2, pick8(in2, int'(sel2)));
            chk("comb.rsel", {4'd0, os2}, {4'd0, sel2});
            chk("comb.rv", {7'd0, ov2}, {7'd0, v2});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
